// File: rtl/bnn_pkg.sv
// Shared defaults and state encoding for the BNN layer datapath.
package bnn_pkg;
  localparam int FAN_IN_DEF    = 784;
  localparam int NEURONS_DEF   = 1024;
  localparam int ALU_WIDTH     = 12;
  localparam int IDX_WIDTH_DEF = 10;
  localparam int THRESH_DEF    = FAN_IN_DEF / 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;
endpackage

// File: rtl/bnn_result_slice.sv
// One-entry valid/ready register; clr_i empties it synchronously.
module bnn_result_slice
  import bnn_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/bnn_neuron_accumulator.sv
// Bit-serial match counter with sign activation and per-layer neuron index.
module bnn_neuron_accumulator
  import bnn_pkg::*;
#(
  parameter int FAN_IN    = FAN_IN_DEF,
  parameter int NEURONS   = NEURONS_DEF,
  parameter int ACC_WIDTH = ALU_WIDTH,
  parameter int IDX_WIDTH = IDX_WIDTH_DEF,
  parameter int THRESH    = THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_count,
  output logic                 out_act,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic                 layer_done
);
  if (FAN_IN >= 2**ACC_WIDTH) begin : g_bad_acc
    $error("ACC_WIDTH too narrow for FAN_IN");
  end
  if (NEURONS > 2**IDX_WIDTH) begin : g_bad_idx
    $error("IDX_WIDTH too narrow for NEURONS");
  end

  localparam logic [ACC_WIDTH-1:0] LAST_BIT = ACC_WIDTH'(FAN_IN - 1);
  localparam logic [ACC_WIDTH-1:0] THR      = ACC_WIDTH'(THRESH);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NEURONS - 1);
  localparam int                   SW       = ACC_WIDTH + 1 + IDX_WIDTH;

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_WIDTH-1:0] nidx_q, nidx_d;
  logic                 layer_done_q, layer_done_d;
  logic [ACC_WIDTH-1:0] result;
  logic                 last_bit, accept, load, consume;
  logic [SW-1:0]        slice_q;

  assign last_bit = (bit_cnt_q == LAST_BIT);
  // Only the closing bit stalls: it alone would overwrite a held result.
  assign in_ready = (state_q == ACCUM) &&
                    !(last_bit && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && last_bit;
  assign consume  = out_valid && out_ready;
  assign result   = acc_q + ACC_WIDTH'(!in_bit);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    nidx_d       = nidx_q;
    layer_done_d = consume && (out_idx == IDX_LAST);
    if (!en) begin
      state_d      = IDLE;
      acc_d        = '0;
      bit_cnt_d    = '0;
      nidx_d       = '0;
      layer_done_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ACCUM;
        ACCUM: begin
          if (accept && last_bit) begin
            acc_d     = '0;
            bit_cnt_d = '0;
            nidx_d    = (nidx_q == IDX_LAST) ? '0 :
                        nidx_q + IDX_WIDTH'(1);
          end else if (accept) begin
            acc_d     = result;
            bit_cnt_d = bit_cnt_q + ACC_WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      nidx_q       <= '0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      nidx_q       <= nidx_d;
      layer_done_q <= layer_done_d;
    end
  end

  bnn_result_slice #(
    .WIDTH(SW)
  ) u_slice (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (!en),
    .load_i (load),
    .data_i ({result, (result >= THR), nidx_q}),
    .ready_i(out_ready),
    .valid_o(out_valid),
    .data_o (slice_q)
  );

  assign {out_count, out_act, out_idx} = slice_q;
  assign layer_done = layer_done_q;
endmodule

// File: doc/bnn_neuron_accumulator.md
Name: bnn_neuron_accumulator

Overview:
- Downstream consumer of the compute stage's bit-serial mismatch stream (weight XOR activation, 1 bit per cycle).
- Counts matches over one neuron's fan-in, applies a binary sign activation against a threshold, and presents one result per neuron through a one-entry valid/ready output buffer.
- Tracks the neuron index within a layer and flags layer completion, so the layer-sequencing FSM can move on to the next layer.

Parameters:
- FAN_IN, 784, input bits per neuron.
- NEURONS, 1024, neurons per layer.
- ACC_WIDTH, 12, match-counter width; must hold FAN_IN.
- IDX_WIDTH, 10, neuron-index width; 2**IDX_WIDTH >= NEURONS.
- THRESH, 392, activation threshold: act = (count >= THRESH).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- en  input  1  synchronous enable; low = synchronous clear.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  XOR mismatch bit (1 = mismatch, 0 = match).
- in_ready  output  1  block accepts in_bit this cycle.
- out_valid  output  1  result buffer holds a result.
- out_ready  input  1  consumer takes the result.
- out_count  output  ACC_WIDTH  match count for the neuron.
- out_act  output  1  activated bit.
- out_idx  output  IDX_WIDTH  neuron index of the result.
- layer_done  output  1  one-cycle pulse, last neuron of the layer consumed.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (rst=0): in_ready=0; out_valid=0; out_count=0; out_act=0; out_idx=0; layer_done=0. Internal bit_cnt, acc and neuron counter are 0; FSM is in IDLE.
- en=0: same clear as reset, applied synchronously at the clock edge. Partial accumulation is discarded. en outranks every other input.
- FSM states:
  - IDLE: in_ready=0. Goes to ACCUM on the first cycle with en=1.
  - ACCUM: normal operation.
  - There is no separate hold state. The stall is expressed through in_ready.
- Accept: an input is accepted when in_valid && in_ready. On accept:
  - acc <= acc + ~in_bit.
  - bit_cnt <= bit_cnt + 1.
- in_valid=0 cycles are bubbles: no state change.
- Last bit: an accept with bit_cnt == FAN_IN-1.
  - Result = acc + ~in_bit.
  - It loads the output buffer on that edge; out_valid rises the next cycle (latency 1 cycle from last-bit accept).
  - acc and bit_cnt return to 0 on the same edge, so the next neuron can start with no bubble.
- out_act = (result >= THRESH), registered with out_count. The comparison is unsigned at ACC_WIDTH.
- Output buffer:
  - Cleared when out_valid && out_ready.
  - Contents are stable while out_valid && !out_ready.
  - A simultaneous consume and load of the next result is legal: the buffer is reloaded and out_valid stays 1.
- Backpressure: in_ready = (state==ACCUM) && !(bit_cnt == FAN_IN-1 && out_valid && !out_ready).
  - Only the final bit of a neuron can stall, and only while the previous result is still unconsumed.
  - Earlier bits keep flowing.
- Neuron index:
  - out_idx is the index of the buffered result.
  - The internal neuron counter increments on each buffer load and wraps NEURONS-1 -> 0.
- layer_done:
  - Pulses for one cycle, the cycle after the handshake that consumes the result with out_idx == NEURONS-1.
  - Accumulation of neuron 0 of the next layer may already be in progress.
- No overflow is possible: the count never exceeds FAN_IN. Elaboration must fail if FAN_IN >= 2**ACC_WIDTH or NEURONS > 2**IDX_WIDTH.
- Async reset mid-neuron or mid-handshake: all state is lost immediately. out_valid drops without a handshake.

Decomposition:
- Shared package bnn_pkg holds:
  - Defaults FAN_IN=784, NEURONS=1024, ALU_WIDTH=12, IDX_WIDTH=10.
  - A FAN_IN/2 threshold constant.
  - The FSM state encoding (IDLE, ACCUM).
- The compute stage and this block both import the package.
- One sub-module is natural: bnn_result_slice, a one-entry valid/ready register for {count, act, idx}. It is reusable for the per-layer activation write-back path.

Test Plan (sim params FAN_IN=8, THRESH=4, NEURONS=4, ACC_WIDTH=4, IDX_WIDTH=2):
- All-match: 8 accepted bits of 0, out_ready=1 -> out_valid high the cycle after the 8th accept; out_count=8, out_act=1, out_idx=0.
- Threshold boundary: bits 1,1,1,1,0,0,0,0 -> count=4, act=1. Bits 1,1,1,1,1,0,0,0 -> count=3, act=0.
- Backpressure: out_ready=0, two neurons streamed back-to-back -> in_ready=0 only at the 16th bit; bits 9-15 are accepted. Raise out_ready -> first result (idx 0) consumed; 16th bit accepted the same cycle; second result (idx 1) appears next cycle.
- Layer wrap: 4 neurons with out_ready=1 -> out_idx 0,1,2,3; layer_done pulses once, the cycle after idx 3 is consumed. The 5th neuron reports idx 0.
- Bubbles: in_valid toggled every other cycle over 8 bits -> same count as a dense stream; out_valid one cycle after the final accept.
- Abort: en=0 (and separately rst=0) after 5 bits with a result buffered -> all outputs at reset values. 8 fresh bits then produce count from those 8 only, idx=0.
